// File: rtl/seg_display_mux_pkg.sv
// Shared definitions for the two-digit seven-segment scan multiplexer:
// scan state encoding and segment patterns (bit0=a ... bit6=g).
package seg_display_mux_pkg;

    typedef enum logic [1:0] {
        ST_TENS  = 2'd0,
        ST_GAP_T = 2'd1,
        ST_ONES  = 2'd2,
        ST_GAP_O = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/seg_display_mux_seg7_decode.sv
// BCD digit to seven-segment pattern; non-decimal codes show a dash
// so a corrupted upstream value is visible rather than misleading.
module seg7_decode
    import seg_display_mux_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Two-digit multiplexed seven-segment driver with anti-ghosting gaps,
// frame-synchronous input capture, leading-zero blanking and blink.
//
// state    | meaning
// TENS     | tens digit enabled for SCAN_DIV cycles
// GAP_T    | all digits off for GUARD cycles
// ONES     | ones digit enabled for SCAN_DIV cycles
// GAP_O    | all digits off for GUARD cycles; inputs captured on exit
module seg_display_mux
    import seg_display_mux_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 50
)
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic       blank_lz_i,
    input  logic       blink_i,
    output logic [6:0] seg_o,
    output logic [1:0] dig_o
);

    localparam int CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] phase_cnt_q;
    logic [FRM_W-1:0] frame_cnt_q;
    logic [3:0]       tens_q, ones_q;
    logic             blank_lz_q, blink_q, blink_on_q;

    logic             phase_done;
    logic             frame_start;
    logic             blank_tens;
    logic             dark;
    logic [3:0]       digit_sel;
    logic [6:0]       seg_dec;

    seg7_decode u_decode (
        .digit (digit_sel),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_GAP_O;
            phase_cnt_q <= '0;
            frame_cnt_q <= '0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            blank_lz_q  <= 1'b0;
            blink_q     <= 1'b0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (phase_done) begin
                phase_cnt_q <= '0;
            end else begin
                phase_cnt_q <= phase_cnt_q + CNT_W'(1);
            end
            // Capture everything at frame start so a frame never mixes old and new values
            if (frame_start) begin
                tens_q     <= tens_i;
                ones_q     <= ones_i;
                blank_lz_q <= blank_lz_i;
                blink_q    <= blink_i;
                if (frame_cnt_q == FRM_LAST) begin
                    frame_cnt_q <= '0;
                    blink_on_q  <= ~blink_on_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FRM_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_done  = 1'b0;
        frame_start = 1'b0;
        digit_sel   = tens_q;
        dig_o       = 2'b00;
        seg_o       = 7'h00;
        blank_tens  = blank_lz_q && (tens_q == 4'd0);
        dark        = blink_q && !blink_on_q;

        case (state_q)
            ST_TENS: begin
                phase_done = (phase_cnt_q == SCAN_LAST);
                if (phase_done) state_d = ST_GAP_T;
                if (!dark && !blank_tens) begin
                    dig_o = 2'b10;
                    seg_o = seg_dec;
                end
            end
            ST_GAP_T: begin
                phase_done = (phase_cnt_q == GUARD_LAST);
                if (phase_done) state_d = ST_ONES;
            end
            ST_ONES: begin
                phase_done = (phase_cnt_q == SCAN_LAST);
                digit_sel  = ones_q;
                if (phase_done) state_d = ST_GAP_O;
                if (!dark) begin
                    dig_o = 2'b01;
                    seg_o = seg_dec;
                end
            end
            ST_GAP_O: begin
                phase_done  = (phase_cnt_q == GUARD_LAST);
                frame_start = phase_done;
                if (phase_done) state_d = ST_TENS;
            end
            default: state_d = ST_GAP_O;
        endcase
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux with a 10-cycle frame
// (SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2); expected {dig,seg} per cycle are queued.
module tb_seg_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       blank_lz = 1'b0;
    logic       blink = 1'b0;
    logic [6:0] seg;
    logic [1:0] dig;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       blank_lz;
        logic [1:0] t_dig;
        logic [6:0] t_seg;
        logic [6:0] o_seg;
    } vec_t;

    vec_t vecs[8];

    seg_display_mux #(
        .SCAN_DIV     (4),
        .GUARD        (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tens_i     (tens),
        .ones_i     (ones),
        .blank_lz_i (blank_lz),
        .blink_i    (blink),
        .seg_o      (seg),
        .dig_o      (dig)
    );

    always #5 clk = ~clk;

    task automatic push_dark(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(9'h000);
    endtask

    // One frame starting at TENS: 4 tens, 1 gap, 4 ones, 1 gap
    task automatic push_frame(input logic [1:0] td, input logic [6:0] ts,
                              input logic [1:0] od, input logic [6:0] os);
        for (int i = 0; i < 4; i++) exp_q.push_back({td, ts});
        exp_q.push_back(9'h000);
        for (int i = 0; i < 4; i++) exp_q.push_back({od, os});
        exp_q.push_back(9'h000);
    endtask

    task automatic check_cycles(input int n, input string tag);
        logic [8:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s cycle %0d: no expected value queued, got dig=%b seg=%h",
                         tag, i, dig, seg);
            end else begin
                e = exp_q.pop_front();
                if ({dig, seg} !== e) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d: got dig=%b seg=%h, expected dig=%b seg=%h",
                             tag, i, dig, seg, e[8:7], e[6:0]);
                end
            end
        end
    endtask

    // Reset edge is followed by one dark GAP_O cycle before TENS
    task automatic do_reset(input string tag);
        rst = 1'b1;
        push_dark(1);
        check_cycles(1, tag);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd4,  4'd2,  1'b0, 2'b10, 7'h66, 7'h5B};
        vecs[1] = '{4'd0,  4'd5,  1'b1, 2'b00, 7'h00, 7'h6D};
        vecs[2] = '{4'd12, 4'd9,  1'b0, 2'b10, 7'h40, 7'h6F};
        vecs[3] = '{4'd0,  4'd0,  1'b0, 2'b10, 7'h3F, 7'h3F};
        vecs[4] = '{4'd8,  4'd7,  1'b0, 2'b10, 7'h7F, 7'h07};
        vecs[5] = '{4'd1,  4'd3,  1'b1, 2'b10, 7'h06, 7'h4F};
        vecs[6] = '{4'd15, 4'd6,  1'b0, 2'b10, 7'h40, 7'h7D};
        vecs[7] = '{4'd9,  4'd10, 1'b0, 2'b10, 7'h6F, 7'h40};

        @(negedge clk);

        // Held reset stays dark
        rst = 1'b1;
        push_dark(4);
        check_cycles(4, "reset_hold");

        foreach (vecs[k]) begin
            tens     = vecs[k].tens;
            ones     = vecs[k].ones;
            blank_lz = vecs[k].blank_lz;
            blink    = 1'b0;
            do_reset("vec_reset");
            push_frame(vecs[k].t_dig, vecs[k].t_seg, 2'b01, vecs[k].o_seg);
            push_frame(vecs[k].t_dig, vecs[k].t_seg, 2'b01, vecs[k].o_seg);
            check_cycles(20, $sformatf("vec%0d", k));
        end

        // Inputs changed mid-frame take effect only at the next frame
        tens = 4'd4; ones = 4'd2; blank_lz = 1'b0; blink = 1'b0;
        do_reset("tear_reset");
        push_frame(2'b10, 7'h66, 2'b01, 7'h5B);
        push_frame(2'b10, 7'h07, 2'b01, 7'h6F);
        check_cycles(2, "tear_a");
        tens = 4'd7; ones = 4'd9;
        check_cycles(6, "tear_b");
        blank_lz = 1'b1; tens = 4'd7;
        check_cycles(12, "tear_c");

        // Blink: first frame after reset lit, then two dark, two lit, ...
        tens = 4'd4; ones = 4'd2; blank_lz = 1'b0; blink = 1'b1;
        do_reset("blink_reset");
        push_frame(2'b10, 7'h66, 2'b01, 7'h5B);
        push_dark(20);
        push_frame(2'b10, 7'h66, 2'b01, 7'h5B);
        push_frame(2'b10, 7'h66, 2'b01, 7'h5B);
        push_dark(10);
        check_cycles(60, "blink");

        // Blink counter keeps running while blink_i is low
        tens = 4'd3; ones = 4'd8; blink = 1'b0;
        do_reset("blinkrun_reset");
        push_frame(2'b10, 7'h4F, 2'b01, 7'h7F);
        push_dark(20);
        push_frame(2'b10, 7'h4F, 2'b01, 7'h7F);
        check_cycles(3, "blinkrun_a");
        blink = 1'b1;
        check_cycles(37, "blinkrun_b");

        // One-cycle reset in the middle of TENS
        tens = 4'd4; ones = 4'd2; blink = 1'b0;
        do_reset("midrst_reset");
        push_dark(0);
        exp_q.push_back({2'b10, 7'h66});
        exp_q.push_back({2'b10, 7'h66});
        check_cycles(2, "midrst_pre");
        tens = 4'd3; ones = 4'd8;
        do_reset("midrst_pulse");
        push_frame(2'b10, 7'h4F, 2'b01, 7'h7F);
        check_cycles(10, "midrst_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
